// File: rtl/multicycle_ctrl_if.sv
// Control-unit bundle for the multicycle RV32I core: instruction fields and the
// ALU zero flag flow into the controller; mux selects, write enables and debug
// state flow back out to the datapath.
interface multicycle_ctrl_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic [1:0] immsrc;
  logic [1:0] alusrca;
  logic [1:0] alusrcb;
  logic [1:0] resultsrc;
  logic       adrsrc;
  logic       irwrite;
  logic       pcwrite;
  logic       regwrite;
  logic       memwrite;
  logic [2:0] alucontrol;
  logic       illegal;
  logic [3:0] state;

  // Controller side: consumes instruction fields, drives every control.
  modport master (
    input  op, funct3, funct7b5, zero,
    output immsrc, alusrca, alusrcb, resultsrc, adrsrc, irwrite, pcwrite,
           regwrite, memwrite, alucontrol, illegal, state
  );

  // Datapath side: supplies instruction fields, obeys the controls.
  modport slave (
    output op, funct3, funct7b5, zero,
    input  immsrc, alusrca, alusrcb, resultsrc, adrsrc, irwrite, pcwrite,
           regwrite, memwrite, alucontrol, illegal, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control unit for the multicycle RV32I core. A Moore FSM steps each
// instruction through 3-5 cycles, sharing one ALU and one memory port.
// Supports lw, sw, R-type ALU, I-type ALU, beq and jal.
module multicycle_ctrl (
  input  logic             clk,
  input  logic             reset,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    ALUWB    = 4'd7,
    EXECI    = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10
  } statetype;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  statetype   statereg;
  statetype   nextstate;

  logic [1:0] aluop;
  logic       branch;
  logic       pcupdate;
  logic       irwritefsm;
  logic       regwritefsm;
  logic       memwritefsm;
  logic       illegalop;

  // State register; reset always returns to FETCH, abandoning any instruction.
  always_ff @(posedge clk) begin
    if (reset) statereg <= FETCH;
    else       statereg <= nextstate;
  end

  // Next-state logic; DECODE dispatches on opcode, unknown opcodes act as NOP.
  always_comb begin
    nextstate = FETCH;
    case (statereg)
      FETCH:    nextstate = DECODE;
      DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: nextstate = MEMADR;
          OP_R:         nextstate = EXECR;
          OP_I:         nextstate = EXECI;
          OP_BEQ:       nextstate = BEQ;
          OP_JAL:       nextstate = JAL;
          default:      nextstate = FETCH;
        endcase
      end
      MEMADR:   nextstate = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  nextstate = MEMWB;
      MEMWB:    nextstate = FETCH;
      MEMWRITE: nextstate = FETCH;
      EXECR:    nextstate = ALUWB;
      EXECI:    nextstate = ALUWB;
      JAL:      nextstate = ALUWB;
      ALUWB:    nextstate = FETCH;
      BEQ:      nextstate = FETCH;
      default:  nextstate = FETCH;
    endcase
  end

  // Flags opcodes outside the supported subset so DECODE can report them.
  always_comb begin
    illegalop = 1'b1;
    case (bus.op)
      OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: illegalop = 1'b0;
      default:                                  illegalop = 1'b1;
    endcase
  end

  // Moore outputs: mux selects and raw enables as a function of state.
  always_comb begin
    bus.alusrca   = 2'b00;
    bus.alusrcb   = 2'b00;
    bus.resultsrc = 2'b00;
    bus.adrsrc    = 1'b0;
    aluop         = 2'b00;
    branch        = 1'b0;
    pcupdate      = 1'b0;
    irwritefsm    = 1'b0;
    regwritefsm   = 1'b0;
    memwritefsm   = 1'b0;
    bus.illegal   = 1'b0;
    case (statereg)
      FETCH: begin
        bus.alusrcb   = 2'b10;
        bus.resultsrc = 2'b10;
        irwritefsm    = 1'b1;
        pcupdate      = 1'b1;
      end
      DECODE: begin
        bus.alusrca = 2'b01;
        bus.alusrcb = 2'b01;
        bus.illegal = illegalop;
      end
      MEMADR: begin
        bus.alusrca = 2'b10;
        bus.alusrcb = 2'b01;
      end
      MEMREAD: begin
        bus.adrsrc = 1'b1;
      end
      MEMWB: begin
        bus.resultsrc = 2'b01;
        regwritefsm   = 1'b1;
      end
      MEMWRITE: begin
        bus.adrsrc  = 1'b1;
        memwritefsm = 1'b1;
      end
      EXECR: begin
        bus.alusrca = 2'b10;
        aluop       = 2'b10;
      end
      EXECI: begin
        bus.alusrca = 2'b10;
        bus.alusrcb = 2'b01;
        aluop       = 2'b10;
      end
      ALUWB: begin
        regwritefsm = 1'b1;
      end
      JAL: begin
        bus.alusrca = 2'b01;
        bus.alusrcb = 2'b10;
        pcupdate    = 1'b1;
      end
      BEQ: begin
        bus.alusrca = 2'b10;
        aluop       = 2'b01;
        branch      = 1'b1;
      end
      default: ;
    endcase
  end

  // Immediate format depends only on opcode, so it is valid in every state.
  always_comb begin
    bus.immsrc = 2'b00;
    case (bus.op)
      OP_SW:   bus.immsrc = 2'b01;
      OP_BEQ:  bus.immsrc = 2'b10;
      OP_JAL:  bus.immsrc = 2'b11;
      default: bus.immsrc = 2'b00;
    endcase
  end

  // ALU decoder; only register-register funct3=000 with funct7b5 selects sub.
  always_comb begin
    bus.alucontrol = 3'b000;
    case (aluop)
      2'b00: bus.alucontrol = 3'b000;
      2'b01: bus.alucontrol = 3'b001;
      2'b10: begin
        case (bus.funct3)
          3'b000:  bus.alucontrol = (bus.op[5] & bus.funct7b5) ? 3'b001 : 3'b000;
          3'b010:  bus.alucontrol = 3'b101;
          3'b110:  bus.alucontrol = 3'b011;
          3'b111:  bus.alucontrol = 3'b010;
          default: bus.alucontrol = 3'b000;
        endcase
      end
      default: bus.alucontrol = 3'b000;
    endcase
  end

  // Architectural write enables are suppressed for the whole reset window.
  assign bus.irwrite  = irwritefsm  & ~reset;
  assign bus.regwrite = regwritefsm & ~reset;
  assign bus.memwrite = memwritefsm & ~reset;
  assign bus.pcwrite  = (pcupdate | (branch & bus.zero)) & ~reset;
  assign bus.state    = statereg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each supported instruction through
// its state sequence and checks controls against hand-computed values.
module tb_multicycle_ctrl;

  logic clk;
  logic reset;
  int   total;
  int   passed;
  int   failed;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives instruction fields mid-cycle, away from the rising edge.
  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3,
                               input logic f7b5, input logic z);
    bus.op       = op;
    bus.funct3   = f3;
    bus.funct7b5 = f7b5;
    bus.zero     = z;
    #1;
  endtask

  // Advances one clock and settles before any sampling.
  task automatic stepClock();
    @(posedge clk);
    #2;
  endtask

  // One comparison: counts it and reports tag/observed/expected on mismatch.
  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    total++;
    assert (observed === expected) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    total  = 0;
    passed = 0;
    failed = 0;
    reset  = 1'b1;
    applyStimulus(7'b0000000, 3'b000, 1'b0, 1'b0);

    // Reset held for two cycles.
    stepClock();
    checkOutput("rst1_state", 8'(bus.state), 8'd0);
    checkOutput("rst1_irwrite", 8'(bus.irwrite), 8'd0);
    checkOutput("rst1_pcwrite", 8'(bus.pcwrite), 8'd0);
    stepClock();
    checkOutput("rst2_state", 8'(bus.state), 8'd0);
    checkOutput("rst2_regwrite", 8'(bus.regwrite), 8'd0);
    checkOutput("rst2_memwrite", 8'(bus.memwrite), 8'd0);
    reset = 1'b0;
    #1;
    checkOutput("fetch_irwrite", 8'(bus.irwrite), 8'd1);
    checkOutput("fetch_pcwrite", 8'(bus.pcwrite), 8'd1);
    checkOutput("fetch_alusrcb", 8'(bus.alusrcb), 8'd2);
    checkOutput("fetch_alucontrol", 8'(bus.alucontrol), 8'd0);
    checkOutput("fetch_resultsrc", 8'(bus.resultsrc), 8'd2);

    // lw: 0,1,2,3,4,0
    applyStimulus(7'b0000011, 3'b010, 1'b0, 1'b0);
    checkOutput("lw_immsrc", 8'(bus.immsrc), 8'd0);
    stepClock();
    checkOutput("lw_s1", 8'(bus.state), 8'd1);
    checkOutput("lw_s1_irwrite", 8'(bus.irwrite), 8'd0);
    stepClock();
    checkOutput("lw_s2", 8'(bus.state), 8'd2);
    checkOutput("lw_s2_alusrca", 8'(bus.alusrca), 8'd2);
    checkOutput("lw_s2_alusrcb", 8'(bus.alusrcb), 8'd1);
    stepClock();
    checkOutput("lw_s3", 8'(bus.state), 8'd3);
    checkOutput("lw_s3_adrsrc", 8'(bus.adrsrc), 8'd1);
    checkOutput("lw_s3_regwrite", 8'(bus.regwrite), 8'd0);
    stepClock();
    checkOutput("lw_s4", 8'(bus.state), 8'd4);
    checkOutput("lw_s4_regwrite", 8'(bus.regwrite), 8'd1);
    checkOutput("lw_s4_resultsrc", 8'(bus.resultsrc), 8'd1);
    checkOutput("lw_s4_memwrite", 8'(bus.memwrite), 8'd0);
    checkOutput("lw_s4_immsrc", 8'(bus.immsrc), 8'd0);
    stepClock();
    checkOutput("lw_end", 8'(bus.state), 8'd0);

    // sw: 0,1,2,5,0
    applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b0);
    checkOutput("sw_immsrc", 8'(bus.immsrc), 8'd1);
    stepClock();
    checkOutput("sw_s1", 8'(bus.state), 8'd1);
    stepClock();
    checkOutput("sw_s2", 8'(bus.state), 8'd2);
    checkOutput("sw_s2_memwrite", 8'(bus.memwrite), 8'd0);
    stepClock();
    checkOutput("sw_s5", 8'(bus.state), 8'd5);
    checkOutput("sw_s5_memwrite", 8'(bus.memwrite), 8'd1);
    checkOutput("sw_s5_adrsrc", 8'(bus.adrsrc), 8'd1);
    checkOutput("sw_s5_regwrite", 8'(bus.regwrite), 8'd0);
    stepClock();
    checkOutput("sw_end", 8'(bus.state), 8'd0);

    // R-type sub: 0,1,6,7,0
    applyStimulus(7'b0110011, 3'b000, 1'b1, 1'b0);
    stepClock();
    checkOutput("rsub_s1", 8'(bus.state), 8'd1);
    stepClock();
    checkOutput("rsub_s6", 8'(bus.state), 8'd6);
    checkOutput("rsub_alucontrol", 8'(bus.alucontrol), 8'd1);
    checkOutput("rsub_alusrcb", 8'(bus.alusrcb), 8'd0);
    stepClock();
    checkOutput("rsub_s7", 8'(bus.state), 8'd7);
    checkOutput("rsub_s7_regwrite", 8'(bus.regwrite), 8'd1);
    checkOutput("rsub_s7_resultsrc", 8'(bus.resultsrc), 8'd0);
    stepClock();
    checkOutput("rsub_end", 8'(bus.state), 8'd0);

    // I-type addi with funct7b5 set must still add.
    applyStimulus(7'b0010011, 3'b000, 1'b1, 1'b0);
    stepClock();
    stepClock();
    checkOutput("iadd_s8", 8'(bus.state), 8'd8);
    checkOutput("iadd_alucontrol", 8'(bus.alucontrol), 8'd0);
    checkOutput("iadd_alusrcb", 8'(bus.alusrcb), 8'd1);
    stepClock();
    checkOutput("iadd_s7", 8'(bus.state), 8'd7);
    stepClock();
    checkOutput("iadd_end", 8'(bus.state), 8'd0);

    // R-type and (funct3=111).
    applyStimulus(7'b0110011, 3'b111, 1'b0, 1'b0);
    stepClock();
    stepClock();
    checkOutput("rand_alucontrol", 8'(bus.alucontrol), 8'd2);
    stepClock();
    stepClock();

    // I-type slti (funct3=010) and ori (funct3=110).
    applyStimulus(7'b0010011, 3'b010, 1'b0, 1'b0);
    stepClock();
    stepClock();
    checkOutput("islt_alucontrol", 8'(bus.alucontrol), 8'd5);
    stepClock();
    stepClock();
    applyStimulus(7'b0010011, 3'b110, 1'b0, 1'b0);
    stepClock();
    stepClock();
    checkOutput("ior_alucontrol", 8'(bus.alucontrol), 8'd3);
    stepClock();
    stepClock();

    // beq taken: 0,1,10,0
    applyStimulus(7'b1100011, 3'b000, 1'b0, 1'b1);
    checkOutput("beq_immsrc", 8'(bus.immsrc), 8'd2);
    stepClock();
    checkOutput("beqt_s1", 8'(bus.state), 8'd1);
    checkOutput("beqt_s1_pcwrite", 8'(bus.pcwrite), 8'd0);
    stepClock();
    checkOutput("beqt_s10", 8'(bus.state), 8'd10);
    checkOutput("beqt_alucontrol", 8'(bus.alucontrol), 8'd1);
    checkOutput("beqt_pcwrite", 8'(bus.pcwrite), 8'd1);
    stepClock();
    checkOutput("beqt_end", 8'(bus.state), 8'd0);

    // beq not taken.
    applyStimulus(7'b1100011, 3'b000, 1'b0, 1'b0);
    stepClock();
    stepClock();
    checkOutput("beqn_s10", 8'(bus.state), 8'd10);
    checkOutput("beqn_pcwrite", 8'(bus.pcwrite), 8'd0);
    stepClock();
    checkOutput("beqn_end", 8'(bus.state), 8'd0);

    // jal: 0,1,9,7,0
    applyStimulus(7'b1101111, 3'b000, 1'b0, 1'b0);
    checkOutput("jal_immsrc", 8'(bus.immsrc), 8'd3);
    stepClock();
    stepClock();
    checkOutput("jal_s9", 8'(bus.state), 8'd9);
    checkOutput("jal_pcwrite", 8'(bus.pcwrite), 8'd1);
    checkOutput("jal_alusrca", 8'(bus.alusrca), 8'd1);
    checkOutput("jal_alusrcb", 8'(bus.alusrcb), 8'd2);
    stepClock();
    checkOutput("jal_s7", 8'(bus.state), 8'd7);
    checkOutput("jal_regwrite", 8'(bus.regwrite), 8'd1);
    stepClock();
    checkOutput("jal_end", 8'(bus.state), 8'd0);

    // Illegal opcode: flagged in DECODE, then straight back to FETCH.
    applyStimulus(7'b1111111, 3'b000, 1'b0, 1'b0);
    checkOutput("ill_fetch_flag", 8'(bus.illegal), 8'd0);
    stepClock();
    checkOutput("ill_s1", 8'(bus.state), 8'd1);
    checkOutput("ill_flag", 8'(bus.illegal), 8'd1);
    checkOutput("ill_regwrite", 8'(bus.regwrite), 8'd0);
    checkOutput("ill_memwrite", 8'(bus.memwrite), 8'd0);
    stepClock();
    checkOutput("ill_end", 8'(bus.state), 8'd0);
    checkOutput("ill_end_flag", 8'(bus.illegal), 8'd0);

    // Reset asserted while in MEMWRITE.
    applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b0);
    stepClock();
    stepClock();
    stepClock();
    checkOutput("rstmw_s5", 8'(bus.state), 8'd5);
    checkOutput("rstmw_pre_memwrite", 8'(bus.memwrite), 8'd1);
    reset = 1'b1;
    #1;
    checkOutput("rstmw_memwrite", 8'(bus.memwrite), 8'd0);
    stepClock();
    checkOutput("rstmw_state", 8'(bus.state), 8'd0);
    checkOutput("rstmw_irwrite", 8'(bus.irwrite), 8'd0);
    reset = 1'b0;
    #1;
    checkOutput("rstmw_release_irwrite", 8'(bus.irwrite), 8'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control unit for the multicycle RV32I core. It sequences the shared ALU, memory port, instruction register and immediate extender across 3–5 cycles per instruction.
- It drives the immediate-extender select (immsrc: 00 I, 01 S, 10 B, 11 J), the ALU operand and result muxes, and all architectural write enables.
- Supported instructions: lw, sw, R-type ALU, I-type ALU, beq, jal.

Parameters:
- None. All widths are fixed by the RV32I encoding.

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  synchronous, active-high
- op  in  7  instr[6:0], taken from the instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag
- immsrc  out  2  immediate-extender format select
- alusrca  out  2  00 PC, 01 oldPC, 10 rs1 data
- alusrcb  out  2  00 rs2 data, 01 immext, 10 constant 4
- resultsrc  out  2  00 ALUOut, 01 read data, 10 ALUResult
- adrsrc  out  1  memory address select: 0 PC, 1 result
- irwrite  out  1  load the instruction register
- pcwrite  out  1  load the PC
- regwrite  out  1  register-file write enable
- memwrite  out  1  data-memory write enable
- alucontrol  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- illegal  out  1  one-cycle pulse on an unsupported opcode
- state  out  4  current FSM state, for debug and the bench

Behaviour:
- Moore FSM with a registered 4-bit state. Every output except pcwrite and alucontrol is a pure function of state (and of op for immsrc).
- pcwrite = pcupdate | (branch & zero), combinational.
- Reset:
  - While reset=1 at a rising edge, state <= FETCH.
  - While reset=1, irwrite, pcwrite, regwrite and memwrite are forced to 0 regardless of state.
  - Reset mid-instruction abandons the instruction; nothing further is written.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BEQ=10. Codes 11–15 go to FETCH on the next edge with all enables at 0.
- Per-state outputs (any signal not listed is 0; muxes not listed are 00):
  - FETCH: adrsrc=0, irwrite=1, alusrca=00, alusrcb=10, aluop=00, resultsrc=10, pcupdate=1.
  - DECODE: alusrca=01, alusrcb=01, aluop=00. Precomputes the branch target.
  - MEMADR: alusrca=10, alusrcb=01, aluop=00.
  - MEMREAD: resultsrc=00, adrsrc=1.
  - MEMWB: resultsrc=01, regwrite=1.
  - MEMWRITE: resultsrc=00, adrsrc=1, memwrite=1.
  - EXECR: alusrca=10, alusrcb=00, aluop=10.
  - EXECI: alusrca=10, alusrcb=01, aluop=10.
  - ALUWB: resultsrc=00, regwrite=1.
  - JAL: alusrca=01, alusrcb=10, aluop=00, resultsrc=00, pcupdate=1.
  - BEQ: alusrca=10, alusrcb=00, aluop=01, resultsrc=00, branch=1.
- Transitions:
  - FETCH -> DECODE.
  - DECODE by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - any other op -> FETCH, with illegal=1 during that DECODE cycle (the instruction is treated as a NOP)
  - MEMADR -> MEMREAD if op=0000011, else MEMWRITE.
  - MEMREAD -> MEMWB; MEMWB -> FETCH; MEMWRITE -> FETCH.
  - EXECR, EXECI, JAL -> ALUWB; ALUWB -> FETCH; BEQ -> FETCH.
- Instruction latency (cycles, FETCH inclusive): lw 5; sw, R, I, jal 4; beq 3.
- immsrc, combinational from op in every state:
  - lw 00; sw 01; beq 10; jal 11; I-type 00.
  - R-type and unknown op: 00.
- ALU decoder:
  - aluop=00 -> add; aluop=01 -> sub.
  - aluop=10, decoded by funct3:
    - 000: sub if (op[5] & funct7b5), else add.
    - 010: slt; 110: or; 111: and.
    - Other funct3: add.
  - aluop=11 never occurs and decodes to add.
- op, funct3 and funct7b5 are assumed stable from DECODE until the next FETCH, because the instruction register is written only in FETCH.

Test Plan:
- Reset held for 2 cycles, then released:
  - During reset: state=0 and all write enables 0.
  - First cycle after release: irwrite=1, pcwrite=1, alusrcb=10, alucontrol=000.
- lw (op=0000011): state sequence 0,1,2,3,4,0.
  - immsrc=00 throughout.
  - regwrite=1 only in state 4, with resultsrc=01.
  - memwrite stays 0.
- sw (op=0100011): sequence 0,1,2,5,0.
  - immsrc=01.
  - memwrite=1 only in state 5, with adrsrc=1.
- R-type sub (op=0110011, funct3=000, funct7b5=1): sequence 0,1,6,7,0; alucontrol=001 in state 6.
  - Same stimulus as I-type (op=0010011, funct7b5=1): alucontrol=000 in state 8.
  - funct3=111: alucontrol=010.
- beq (op=1100011):
  - zero=1: in state 10, alucontrol=001 and pcwrite=1.
  - zero=0: pcwrite=0.
  - Either case: returns to FETCH after 3 cycles; immsrc=10.
- Edge cases:
  - jal (op=1101111): sequence 0,1,9,7,0; immsrc=11; pcwrite=1 in state 9; regwrite=1 in state 7.
  - Illegal op 1111111: illegal=1 in DECODE, then state 0, with no regwrite or memwrite.
  - Reset asserted in MEMWRITE: memwrite drops to 0 in that cycle and state=0 next.
